obi_gnt_stall: RTL
==================

Name: obi_gnt_stall

Overview:
- Request-side companion to the OBI response stall FIFO in the example testbench.
- Sits between the core's OBI request port and the RAM model.
- Inserts configurable grant delays (none / fixed / pseudo-random) and limits outstanding transactions.
- Drives the req/gnt/we signals that the downstream response-stall FIFO pushes on.
- Fully synthesizable and Verilator-safe: an internal LFSR replaces $urandom.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, write data width; byte enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 8, granted-but-unanswered transactions allowed; matches the response FIFO depth.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- core_req_i  in  1  OBI request from core.
- core_gnt_o  out  1  OBI grant to core and to the response-stall FIFO.
- core_addr_i  in  ADDR_WIDTH  request address.
- core_we_i  in  1  write enable.
- core_be_i  in  DATA_WIDTH/8  byte enables.
- core_wdata_i  in  DATA_WIDTH  write data.
- mem_req_o  out  1  accepted-transaction strobe to RAM.
- mem_addr_o  out  ADDR_WIDTH  pass-through of core_addr_i.
- mem_we_o  out  1  pass-through of core_we_i.
- mem_be_o  out  DATA_WIDTH/8  pass-through of core_be_i.
- mem_wdata_o  out  DATA_WIDTH  pass-through of core_wdata_i.
- rvalid_i  in  1  response retired; taken from the response FIFO rvalid_o.
- en_stall_i  in  1  master stall enable.
- stall_mode_i  in  32  NONE=0, STANDARD=1, RANDOM=2.
- max_stall_i  in  32  RANDOM upper bound.
- gnt_stall_i  in  32  STANDARD fixed delay.

Behaviour:
- Reset values:
  - state IDLE; delay counter 0; outstanding counter 0; LFSR=LFSR_SEED.
  - core_gnt_o=0; mem_req_o=0.
  - mem_* data outputs are pure combinational pass-throughs, never registered.
- Delay selection, d (4 bits), evaluated in IDLE whenever core_req_i=1:
  - en_stall_i=0, mode NONE, or unknown mode: d=0.
  - STANDARD: d=min(gnt_stall_i,15).
  - RANDOM: m=min(max_stall_i,15); d=lfsr[7:0] % (m+1).
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clock cycle after reset, independent of traffic.
- Grant blocking: grant is blocked whenever outstanding==MAX_OUTSTANDING.
- FSM IDLE:
  - core_req_i=0: stay.
  - core_req_i=1, d=0, not blocked: core_gnt_o=1 combinationally in the same cycle; stay IDLE.
  - core_req_i=1 otherwise: load counter=d (d=0 if only blocked); go to STALL.
- FSM STALL:
  - counter>0: decrement.
  - counter==0 and not blocked: core_gnt_o=1; go to IDLE.
  - Grant cycle = request cycle + d when unblocked.
  - Changes to en_stall_i or mode during STALL do not affect the running count.
- mem_req_o = core_req_i & core_gnt_o.
- Back-to-back: if req is still high in the cycle after a grant, it is a new transaction and a new d is sampled in IDLE.
- Outstanding counter:
  - +1 on core_req_i&core_gnt_o; −1 on rvalid_i; both in the same cycle: unchanged.
  - Saturates; no wrap.
  - A blocked grant can issue no earlier than the cycle after the rvalid_i that frees a slot.
- Core protocol: core_req_i and payload must stay stable from assertion until grant (OBI rule). The block does not re-sample them.
- Reset asserted mid-STALL: immediate return to reset values; the pending request is dropped without a grant.

Optional Feature:
- Macro OBI_GNT_STALL_CHECK_EN.
- Defined: SVA checks are compiled in:
  - core_req_i falls without a grant: error.
  - addr/we/be/wdata change while req is high and gnt is low: error.
  - rvalid_i while outstanding==0: error.
  - outstanding exceeds MAX_OUTSTANDING: error.
- Not defined: no assertions; the RTL is otherwise identical.

Decomposition:
- Package obi_stall_pkg holds:
  - stall mode constants NONE/STANDARD/RANDOM (shared with the response-stall FIFO);
  - DELAY_WL=4 and MAX_DELAY=15;
  - FSM state enum gnt_state_e {IDLE, STALL}.
- Sub-module obi_stall_lfsr: 16-bit LFSR with seed parameter and a per-cycle advance. It is reusable by the response-side stall block.

Test Plan:
- No stall: en_stall_i=0, req high for 3 cycles -> gnt=1 in cycles 0,1,2; mem_req_o pulses 3 times; outstanding=3.
- STANDARD: gnt_stall_i=3, req at cycle 0 held -> gnt only in cycle 3; mem_addr_o equals core_addr_i throughout.
- Clamp: STANDARD, gnt_stall_i=20 -> gnt at cycle 15 exactly.
- Outstanding limit: MAX=8, 9 back-to-back requests, no rvalid_i -> 9th gnt withheld. Pulse rvalid_i at cycle N -> 9th gnt at cycle N+1.
- RANDOM: max_stall_i=2, 1000 requests -> every delay in {0,1,2}, each value observed; identical sequence after re-reset with the same seed.
- Reset mid-STALL: gnt_stall_i=5, assert rst_ni low at cycle 2 -> core_gnt_o=0 immediately. After release a new request is granted 5 cycles later; outstanding=0 before the grant.

Source files
------------

// File: rtl/obi_stall_pkg.sv
// obi_stall_pkg: constants and types shared by the OBI request-side grant
// staller and the response-side stall FIFO.
//   - stall mode encodings NONE / STANDARD / RANDOM (32-bit, as driven by the bench)
//   - DELAY_WL / MAX_DELAY: width and ceiling of an inserted delay
//   - gnt_state_e: grant FSM states
//   - clamp_delay(): saturate a 32-bit delay request to MAX_DELAY
package obi_stall_pkg;

  localparam logic [31:0] NONE     = 32'd0;
  localparam logic [31:0] STANDARD = 32'd1;
  localparam logic [31:0] RANDOM   = 32'd2;

  localparam int unsigned          DELAY_WL  = 4;
  localparam logic [DELAY_WL-1:0]  MAX_DELAY = 4'd15;

  typedef enum logic {IDLE, STALL} gnt_state_e;

  function automatic logic [DELAY_WL-1:0] clamp_delay(input logic [31:0] v);
    return (v > 32'(MAX_DELAY)) ? MAX_DELAY : v[DELAY_WL-1:0];
  endfunction

endpackage

// File: rtl/obi_stall_lfsr.sv
// obi_stall_lfsr: free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
// advancing once per clock out of reset. Used as a cheap, deterministic
// pseudo-random source by the stall blocks.
// Ports:
//   clk_i   clock
//   rst_ni  async active-low reset, loads SEED
//   rnd_o   low OUT_W bits of the current LFSR state
module obi_stall_lfsr #(
  parameter logic [15:0] SEED  = 16'hACE1,  // must be nonzero
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] lfsr;
  logic        fb;

  // right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5
  assign fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign rnd_o = lfsr[OUT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= SEED;
    else         lfsr <= {fb, lfsr[15:1]};
  end

endmodule

// File: rtl/obi_gnt_stall.sv
// obi_gnt_stall: sits between the core OBI request port and the RAM model,
// delaying grants (none / fixed / pseudo-random) and capping the number of
// granted-but-unanswered transactions at MAX_OUTSTANDING.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   core_req_i / core_gnt_o       OBI handshake (gnt also feeds the rsp FIFO)
//   core_addr_i/we_i/be_i/wdata_i request payload
//   mem_req_o                     strobe for an accepted transaction
//   mem_addr/we/be/wdata_o        combinational pass-through of payload
//   rvalid_i                      response retired (frees one slot)
//   en_stall_i, stall_mode_i      stall enable and mode (NONE/STANDARD/RANDOM)
//   max_stall_i, gnt_stall_i      RANDOM bound, STANDARD delay
// Build option: define OBI_GNT_STALL_CHECK_EN to compile in protocol SVA.
module obi_gnt_stall
  import obi_stall_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    core_req_i,
  output logic                    core_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    rvalid_i,
  input  logic                    en_stall_i,
  input  logic [31:0]             stall_mode_i,
  input  logic [31:0]             max_stall_i,
  input  logic [31:0]             gnt_stall_i
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  gnt_state_e          state;
  logic [DELAY_WL-1:0] cnt;
  logic [OW-1:0]       outstd;
  logic [7:0]          rnd;
  logic [DELAY_WL-1:0] d, rand_d;
  logic [15:0]         rand_rem;
  logic                blocked, gnt_raw, inc, dec;

  obi_stall_lfsr #(.SEED(LFSR_SEED), .OUT_W(8)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rnd_o  (rnd)
  );

  assign mem_addr_o  = core_addr_i;
  assign mem_we_o    = core_we_i;
  assign mem_be_o    = core_be_i;
  assign mem_wdata_o = core_wdata_i;

  assign blocked  = (outstd == OW'(MAX_OUTSTANDING));
  assign rand_rem = {8'd0, rnd} % ({12'd0, clamp_delay(max_stall_i)} + 16'd1);
  assign rand_d   = rand_rem[DELAY_WL-1:0];

  always_comb begin
    d = '0;
    if (en_stall_i) begin
      if (stall_mode_i == STANDARD)    d = clamp_delay(gnt_stall_i);
      else if (stall_mode_i == RANDOM) d = rand_d;
    end
    gnt_raw = 1'b0;
    case (state)
      IDLE:    gnt_raw = core_req_i && (d == '0) && !blocked;
      STALL:   gnt_raw = (cnt == '0) && !blocked;
      default: gnt_raw = 1'b0;
    endcase
  end

  // grant is held low while reset is asserted, even though IDLE could
  // otherwise grant a zero-delay request combinationally
  assign core_gnt_o = gnt_raw & rst_ni;
  assign mem_req_o  = core_req_i & core_gnt_o;
  assign inc        = mem_req_o;
  assign dec        = rvalid_i;

  // The counter holds d-1 so that the grant lands exactly d cycles after
  // the request cycle (IDLE itself is the first waiting cycle). A request
  // that is only blocked parks in STALL with cnt=0 until a slot frees up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (core_req_i && !gnt_raw) begin
          cnt   <= (d == '0) ? '0 : d - 1'b1;
          state <= STALL;
        end
        STALL: begin
          if (cnt != '0)    cnt   <= cnt - 1'b1;
          else if (!blocked) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstd <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (!blocked)      outstd <= outstd + 1'b1;
        2'b01:   if (outstd != '0)  outstd <= outstd - 1'b1;
        default: outstd <= outstd;
      endcase
    end
  end

`ifdef OBI_GNT_STALL_CHECK_EN
  a_req_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (core_req_i && !core_gnt_o) |=> core_req_i)
    else $error("core_req_i dropped without grant");
  a_payload: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (core_req_i && !core_gnt_o) |=>
      $stable({core_addr_i, core_we_i, core_be_i, core_wdata_i}))
    else $error("request payload changed before grant");
  a_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_i && outstd == '0))
    else $error("rvalid_i with no outstanding transaction");
  a_limit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstd <= OW'(MAX_OUTSTANDING))
    else $error("outstanding count above limit");
`else
  // default build: no protocol checks
`endif

endmodule
